// File: rtl/ext_pkg.sv
// Shared definitions for the immediate-extension pipeline: op encodings and op width.
package ext_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ZERO   = 2'b00,
        OP_SIGN   = 2'b01,
        OP_UPPER  = 2'b10,
        OP_BRANCH = 2'b11
    } ext_op_e;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extension: zero, sign, upper-placement and branch-offset forms.
module ext_core
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [OP_W-1:0]  op,
    output logic [OUT_W-1:0] ext
);

    logic [OUT_W-1:0] sext_s;

    // Select the extension form requested by op
    always_comb begin
        sext_s = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        case (op)
            OP_ZERO:   ext = {{(OUT_W-IN_W){1'b0}}, imm};
            OP_SIGN:   ext = sext_s;
            OP_UPPER:  ext = {imm, {(OUT_W-IN_W){1'b0}}};
            OP_BRANCH: ext = {sext_s[OUT_W-3:0], 2'b00};
            default:   ext = {OUT_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Two-entry (output register + skid) pipeline that extends immediates at acceptance.
// in_ready comes straight from the skid valid flop, so it never depends on out_ready.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [OP_W-1:0]  in_op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_ext
);

    if (OUT_W < IN_W + 2) begin : g_bad_width
        $error("ext_pipe: OUT_W must be at least IN_W+2");
    end

    logic             or_valid_r;
    logic             sk_valid_r;
    logic [OUT_W-1:0] or_data_r;
    logic [OUT_W-1:0] sk_data_r;

    logic             or_valid_s;
    logic             sk_valid_s;
    logic [OUT_W-1:0] or_data_s;
    logic [OUT_W-1:0] sk_data_s;
    logic [OUT_W-1:0] ext_s;
    logic             accept_s;
    logic             consume_s;

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm (in_imm),
        .op  (in_op),
        .ext (ext_s)
    );

    assign in_ready  = ~sk_valid_r;
    assign out_valid = or_valid_r;
    assign out_ext   = or_data_r;
    assign accept_s  = in_valid & ~sk_valid_r;
    assign consume_s = or_valid_r & out_ready;

    // Next-state of both entries; skid is only ever valid while OR is valid
    always_comb begin
        or_valid_s = or_valid_r;
        sk_valid_s = sk_valid_r;
        or_data_s  = or_data_r;
        sk_data_s  = sk_data_r;
        if (flush) begin
            or_valid_s = 1'b0;
            sk_valid_s = 1'b0;
        end else if (consume_s && sk_valid_r) begin
            or_valid_s = 1'b1;
            or_data_s  = sk_data_r;
            sk_valid_s = accept_s;
            if (accept_s) begin
                sk_data_s = ext_s;
            end else begin
                sk_data_s = sk_data_r;
            end
        end else if (!or_valid_r || consume_s) begin
            or_valid_s = accept_s;
            if (accept_s) begin
                or_data_s = ext_s;
            end else begin
                or_data_s = or_data_r;
            end
        end else begin
            if (accept_s) begin
                sk_valid_s = 1'b1;
                sk_data_s  = ext_s;
            end else begin
                sk_valid_s = sk_valid_r;
            end
        end
    end

    // Valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            or_valid_r <= 1'b0;
            sk_valid_r <= 1'b0;
        end else begin
            or_valid_r <= or_valid_s;
            sk_valid_r <= sk_valid_s;
        end
    end

    // Data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            or_data_r <= {OUT_W{1'b0}};
            sk_data_r <= {OUT_W{1'b0}};
        end else begin
            or_data_r <= or_data_s;
            sk_data_r <= sk_data_s;
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Randomized self-checking bench for ext_pipe against a queue-based reference model.
module tb_ext_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_op;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ext;

    logic [31:0] mq[$];
    int          n_checks;
    int          n_fail;

    ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_op     (in_op),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ext   (out_ext)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] op);
        longint v;
        longint r;
        logic [31:0] res;
        v = (imm >= 16'h8000) ? longint'(imm) - 65536 : longint'(imm);
        case (op)
            2'd0:    r = longint'(imm);
            2'd1:    r = v;
            2'd2:    r = longint'(imm) * 65536;
            default: r = v * 4;
        endcase
        r   = r & 64'h0000_0000_FFFF_FFFF;
        res = r[31:0];
        return res;
    endfunction

    // Drive one cycle of inputs, advance the clock and update the model
    task automatic step(input logic iv, input logic [15:0] imm, input logic [1:0] op,
                        input logic ordy, input logic fl, input logic rst);
        bit acc;
        bit con;
        in_valid  = iv;
        in_imm    = imm;
        in_op     = op;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(posedge clk);
        if (rst || fl) begin
            mq.delete();
        end else begin
            acc = iv && (mq.size() < 2);
            con = ordy && (mq.size() > 0);
            if (con) void'(mq.pop_front());
            if (acc) mq.push_back(ref_ext(imm, op));
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h1234, 2'd1, 1'b1, 1'b0, 1'b1);
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (out_ext !== 32'h0) begin n_fail++; $display("FAIL reset_out_ext: got %h want 0", out_ext); end
    endtask

    task automatic test_modes();
        logic [31:0] exp_mode[4];
        exp_mode = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004};
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 16'h8001, 2'(k), 1'b1, 1'b0, 1'b0);
            n_checks += 2;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL modes_valid op%0d: got %b want 1", k, out_valid); end
            if (out_ext !== exp_mode[k]) begin n_fail++; $display("FAIL modes_ext op%0d: got %h want %h", k, out_ext, exp_mode[k]); end
        end
        drain();
    endtask

    task automatic test_stream();
        logic [31:0] exp_q[$];
        logic [15:0] imm;
        logic [1:0]  op;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) begin
                imm = 16'($urandom);
                op  = 2'($urandom_range(0, 3));
                exp_q.push_back(ref_ext(imm, op));
                step(1'b1, imm, op, 1'b1, 1'b0, 1'b0);
            end else begin
                step(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);
            end
            n_checks += 2;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready cyc%0d: got %b want 1", i, in_ready); end
            if (i < 5) begin
                if (out_valid !== 1'b1 || out_ext !== exp_q[i]) begin
                    n_fail++; $display("FAIL stream_out cyc%0d: got v=%b %h want v=1 %h", i, out_valid, out_ext, exp_q[i]);
                end
            end else begin
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_idle cyc%0d: got v=%b want 0", i, out_valid); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, c;
        a = ref_ext(16'h1111, 2'd0);
        b = ref_ext(16'hF222, 2'd1);
        c = ref_ext(16'h0333, 2'd3);
        step(1'b1, 16'h1111, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hF222, 2'd1, 1'b0, 1'b0, 1'b0);
        n_checks += 2;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready: got %b want 0", in_ready); end
        if (out_ext !== a) begin n_fail++; $display("FAIL bp_hold_a: got %h want %h", out_ext, a); end
        step(1'b1, 16'h0333, 2'd3, 1'b0, 1'b0, 1'b0);
        n_checks += 2;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall: got rdy=%b v=%b want 0 1", in_ready, out_valid); end
        if (out_ext !== a) begin n_fail++; $display("FAIL bp_stable_a: got %h want %h", out_ext, a); end
        // Full and consumed: SK moves to OR, C still refused this cycle
        step(1'b1, 16'h0333, 2'd3, 1'b1, 1'b0, 1'b0);
        n_checks += 2;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_sk_move_rdy: got %b want 1", in_ready); end
        if (out_ext !== b) begin n_fail++; $display("FAIL bp_out_b: got %h want %h", out_ext, b); end
        // OR full, SK empty: consume B and accept C in the same cycle
        step(1'b1, 16'h0333, 2'd3, 1'b1, 1'b0, 1'b0);
        n_checks += 2;
        if (out_valid !== 1'b1 || out_ext !== c) begin n_fail++; $display("FAIL bp_out_c: got v=%b %h want v=1 %h", out_valid, out_ext, c); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_c_rdy: got %b want 1", in_ready); end
        step(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got v=%b want 0", out_valid); end
    endtask

    task automatic test_flush();
        step(1'b1, 16'h0A0A, 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0B0B, 2'd2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0C0C, 2'd0, 1'b1, 1'b1, 1'b0);
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped cyc%0d: got v=%b ext=%h want v=0", i, out_valid, out_ext); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        step(1'b1, 16'h7FFF, 2'd3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h8000, 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h1357, 2'd0, 1'b1, 1'b1, 1'b1);
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        if (out_ext !== 32'h0) begin n_fail++; $display("FAIL rstmid_out_ext: got %h want 0", out_ext); end
        d = ref_ext(16'hCAFE, 2'd3);
        step(1'b1, 16'hCAFE, 2'd3, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_ext !== d) begin n_fail++; $display("FAIL rstmid_restart: got v=%b %h want v=1 %h", out_valid, out_ext, d); end
        drain();
    endtask

    task automatic test_random();
        bit iv, ordy, fl, rst;
        for (int i = 0; i < 400; i++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 24) == 0);
            rst  = ($urandom_range(0, 59) == 0);
            step(iv, 16'($urandom), 2'($urandom_range(0, 3)), ordy, fl, rst);
            n_checks += 2;
            if (out_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rand_out_valid cyc%0d: got %b want %b", i, out_valid, mq.size() > 0); end
            if (in_ready !== (mq.size() < 2)) begin n_fail++; $display("FAIL rand_in_ready cyc%0d: got %b want %b", i, in_ready, mq.size() < 2); end
            if (mq.size() > 0) begin
                n_checks++;
                if (out_ext !== mq[0]) begin n_fail++; $display("FAIL rand_out_ext cyc%0d: got %h want %h", i, out_ext, mq[0]); end
            end else if (rst) begin
                n_checks++;
                if (out_ext !== 32'h0) begin n_fail++; $display("FAIL rand_rst_ext cyc%0d: got %h want 0", i, out_ext); end
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_imm    = 16'h0000;
        in_op     = 2'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_modes();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16, immediate input width.
REQ-002 SHALL have parameter OUT_W, default 32, extended output width; OUT_W >= IN_W+2 is required, with an elaboration-time error otherwise.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, upstream offers an immediate.
REQ-006 SHALL have port in_ready, output, 1, block can accept this cycle.
REQ-007 SHALL have port in_imm, input, IN_W, raw immediate.
REQ-008 SHALL have port in_op, input, 2, extension mode.
REQ-009 SHALL have port flush, input, 1, discards all held entries.
REQ-010 SHALL have port out_valid, output, 1, out_ext holds a valid result.
REQ-011 SHALL have port out_ready, input, 1, downstream consumes this cycle.
REQ-012 SHALL have port out_ext, output, OUT_W, extended result.

Function
REQ-013 SHALL transfer on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
REQ-014 SHALL use op 00 ZERO: zero-extend in_imm to OUT_W.
REQ-015 SHALL use op 01 SIGN: sign-extend in_imm, copying bit IN_W-1, to OUT_W.
REQ-016 SHALL use op 10 UPPER: in_imm placed at bits OUT_W-1..OUT_W-IN_W, all lower bits 0 (16/32: imm<<16).
REQ-017 SHALL use op 11 BRANCH: sign-extend in_imm to OUT_W, then shift left by 2, discarding the top 2 bits.
REQ-018 SHALL compute the result at acceptance and store the computed result, not the raw immediate; the result SHALL appear on out_ext with out_valid=1 one cycle after acceptance (latency 1).
REQ-019 SHALL hold state as an output register (OR) plus one skid entry (SK), for a capacity of 2.
REQ-020 SHALL drive in_ready = !SK.valid, a registered value that does not depend combinationally on out_ready.
REQ-021 SHALL load an accepted item into OR when OR is empty or OR is being consumed this cycle with SK empty; otherwise it SHALL load into SK.
REQ-022 SHALL move SK to OR and clear SK when OR is consumed and SK is valid; an item accepted in that same cycle SHALL go to SK.
REQ-023 SHALL hold OR stable (value and out_valid) while out_valid && !out_ready.
REQ-024 SHALL preserve strict FIFO order with no loss and no duplication.
REQ-025 SHALL, when flush=1, clear OR.valid and SK.valid at the next edge; any item offered that cycle SHALL be dropped, and in_ready SHALL be 1 the following cycle.
REQ-026 SHALL let flush dominate a simultaneous accept or consume; an item on the output handshake in a flush cycle counts as consumed by downstream.
REQ-027 SHALL leave out_ext at its last value when out_valid=0; that value has no meaning.

Reset
REQ-028 SHALL, with reset=1 at a rising edge, set OR.valid=0, SK.valid=0, out_ext=0 and SK data=0, so out_valid=0 and in_ready=1.
REQ-029 SHALL let reset take priority over flush and over both handshakes; reset mid-stream discards all held items.

Structure
REQ-030 SHALL place the op encodings ZERO/SIGN/UPPER/BRANCH and the op-width constant in a shared package ext_pkg.
REQ-031 SHALL put the combinational extension in a sub-module ext_core (params IN_W, OUT_W; ports imm, op, ext), instantiated once on the input path.
REQ-032 SHALL keep valid bits and data registers in ext_pipe, with no latches and a single always block per register group.

Verification
REQ-033 SHALL cover modes (IN_W=16, OUT_W=32): in_imm=16'h8001 with op 00/01/10/11 -> out_ext 32'h00008001 / 32'hFFFF8001 / 32'h80010000 / 32'hFFFE0004.
REQ-034 SHALL cover streaming: out_ready=1, five back-to-back items A..E -> out_valid from cycle after A, A..E out in order at one per cycle, in_ready stays 1.
REQ-035 SHALL cover backpressure: out_ready=0, offer A, B, C -> A in OR, B in SK, in_ready=0, C not accepted; raise out_ready -> A, B, then C out in order.
REQ-036 SHALL cover simultaneous events: OR and SK full, out_ready=1 -> SK moves to OR, in_ready=1 next cycle; OR full, SK empty, consume and accept in same cycle -> new item in OR next cycle.
REQ-037 SHALL cover flush: two items held, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, the offered item is never output.
REQ-038 SHALL cover reset mid-operation: two items held, reset=1 for one cycle -> out_valid=0, in_ready=1, out_ext=0, and the stream restarts correctly.
